// File: rtl/input_conditioner.sv
// N-channel push-button front end: synchroniser, debouncer, edge pulses
// and hold-to-auto-repeat press pulses, one independent lane per channel.
module input_conditioner #(
    parameter int N           = 5,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 1000000,
    parameter int CNT_W       = 20,
    parameter int RPT_DELAY   = 25000000,
    parameter int RPT_RATE    = 5000000,
    parameter int RPT_W       = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] press
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(RPT_RATE - 1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt;
        logic [RPT_W-1:0]       t;
        rpt_state_t             state;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   press_q;
        logic                   s;
        logic                   flip;
        logic                   level_nxt;

        assign s         = sync_q[SYNC_STAGES-1];
        assign flip      = (s != level_q) && (cnt == CNT_LAST);
        assign level_nxt = flip ? s : level_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q  <= '0;
                cnt     <= '0;
                t       <= '0;
                state   <= IDLE;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                press_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
                level_q <= level_nxt;
                rise_q  <= flip & s;
                fall_q  <= flip & ~s;
                press_q <= 1'b0;

                if (s == level_q || flip)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;

                // Timers look at the next level so a release beats a
                // repeat tick landing on the same edge.
                unique case (state)
                    IDLE: begin
                        if (flip && s) begin
                            press_q <= 1'b1;
                            if (repeat_en[i]) begin
                                state <= DELAY;
                                t     <= '0;
                            end
                        end
                    end
                    DELAY: begin
                        if (!level_nxt || !repeat_en[i]) begin
                            state <= IDLE;
                        end else if (t == DELAY_LAST) begin
                            press_q <= 1'b1;
                            t       <= '0;
                            state   <= REPEAT;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!level_nxt || !repeat_en[i]) begin
                            state <= IDLE;
                        end else if (t == RATE_LAST) begin
                            press_q <= 1'b1;
                            t       <= '0;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign level[i] = level_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign press[i] = press_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios then random traffic,
// all checked cycle by cycle against a window/elapsed-time model.
module tb_input_conditioner;

    localparam int N     = 2;
    localparam int SYNC  = 2;
    localparam int STAB  = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] press;

    input_conditioner #(
        .N(N), .SYNC_STAGES(SYNC), .STABLE(STAB), .CNT_W(3),
        .RPT_DELAY(RDLY), .RPT_RATE(RRATE), .RPT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
        .level(level), .rise(rise), .fall(fall), .press(press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: history of sampled pins, newest at index 0.
    logic [N-1:0] smp [8];
    logic [N-1:0] m_level, m_rise, m_fall, m_press;
    bit           armed [N];
    int           start [N];
    int           edge_n = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] b,
                              input logic [N-1:0] e);
        bit   flip;
        logic nl;
        int   d;
        edge_n++;
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        if (r) begin
            for (int k = 0; k < 8; k++) smp[k] = '0;
            m_level = '0;
            for (int c = 0; c < N; c++) armed[c] = 0;
            return;
        end
        for (int k = 7; k > 0; k--) smp[k] = smp[k-1];
        smp[0] = b;
        for (int c = 0; c < N; c++) begin
            // Level flips once the last STAB synced samples all disagree.
            flip = 1;
            for (int j = SYNC; j < SYNC + STAB; j++)
                if (smp[j][c] == m_level[c]) flip = 0;
            nl = flip ? ~m_level[c] : m_level[c];
            m_rise[c] = flip & nl;
            m_fall[c] = flip & ~nl;
            if (flip && nl) begin
                m_press[c] = 1'b1;
                armed[c]   = e[c];
                start[c]   = edge_n;
            end else if (armed[c]) begin
                if (!nl || !e[c]) begin
                    armed[c] = 0;
                end else begin
                    d = edge_n - start[c];
                    if (d == RDLY || (d > RDLY && (d - RDLY) % RRATE == 0))
                        m_press[c] = 1'b1;
                end
            end
            m_level[c] = nl;
        end
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] b,
                         input logic [N-1:0] e);
        reset     = r;
        btn_in    = b;
        repeat_en = e;
        @(posedge clk);
        model_step(r, b, e);
        #1;
        chk("level", level, m_level);
        chk("rise",  rise,  m_rise);
        chk("fall",  fall,  m_fall);
        chk("press", press, m_press);
    endtask

    initial begin
        int np;
        int nr;
        logic [N-1:0] b;
        logic [N-1:0] e;
        logic         r;
        for (int k = 0; k < 8; k++) smp[k] = '0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        for (int c = 0; c < N; c++) begin
            armed[c] = 0;
            start[c] = 0;
        end
        reset     = 1'b1;
        btn_in    = '0;
        repeat_en = '0;
        #2;

        // Reset held with both pins pressed.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b11, 2'b00);
            chk("rst_out", level | rise | fall | press, 2'b00);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 2'b00);

        // Clean press: outputs appear after edge 5 for one cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'b01, 2'b00);
            if (i == 4) chk("lvl_e4", level, 2'b00);
            if (i == 5) chk("rise_e5", rise & press, 2'b01);
            if (i == 6) chk("rise_e6", rise | press, 2'b00);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 2'b00);

        // Short glitch is rejected.
        nr = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01, 2'b00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'b00, 2'b00);
            nr += int'(rise[0]) + int'(press[0]);
        end
        chk("glitch_lvl", level, 2'b00);
        chk_int("glitch_pulses", nr, 0);

        // Auto-repeat: rise at 5, then 15, 18, ... 42 inside the hold.
        np = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(1'b0, 2'b01, 2'b01);
            if (press[0]) np++;
            if (i == 14) chk("pre_rpt", press, 2'b00);
            if (i == 15) chk("first_rpt", press, 2'b01);
        end
        chk_int("rpt_count", np, 11);
        np = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 2'b00, 2'b01);
            if (i == 5) chk("rel_fall", fall, 2'b01);
            if (i >= 5 && press[0]) np++;
        end
        chk_int("press_after_fall", np, 0);

        // repeat_en dropped inside DELAY.
        np = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 2'b01, (i < 10) ? 2'b01 : 2'b00);
            if (press[0]) np++;
        end
        chk_int("drop_en_press", np, 1);
        chk("drop_en_lvl", level, 2'b01);
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 2'b00);

        // Both channels together, reset mid-DELAY, full re-debounce.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 2'b11, 2'b11);
            if (i == 5) chk("both_rise", rise, 2'b11);
        end
        cycle(1'b1, 2'b11, 2'b11);
        chk("post_rst", level | rise | fall | press, 2'b00);
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b0, 2'b11, 2'b11);
            if (i == 5) chk("rerun_e5", level, 2'b00);
            if (i == 6) chk("rerun_e6", rise & press, 2'b11);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 2'b00);

        // Random traffic with long holds, bounce and occasional reset.
        b = '0;
        e = 2'b11;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(11) == 0) b[c] = ~b[c];
                if ($urandom_range(29) == 0) e[c] = ~e[c];
            end
            r = ($urandom_range(199) == 0);
            cycle(r, b, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
